// File: rtl/pkt_store.sv
// Pointer-managed payload buffer: writes take handles from an external free-address FIFO, reads return
// payload through a registered stage and queue the freed handle. Optional checker: define PKT_STORE_CHECK_EN.
`timescale 1ns/1ps

module pkt_store #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__free_valid,
  input  logic [ADDR_WIDTH-1:0] i__free_addr,
  output logic                  o__free_ready,
  input  logic                  i__wr_valid,
  input  logic [DATA_WIDTH-1:0] i__wr_data,
  output logic                  o__wr_ready,
  output logic [ADDR_WIDTH-1:0] o__wr_addr,
  input  logic                  i__rd_valid,
  input  logic [ADDR_WIDTH-1:0] i__rd_addr,
  output logic                  o__rd_ready,
  output logic                  o__rd_data_valid,
  output logic [DATA_WIDTH-1:0] o__rd_data,
  input  logic                  i__rd_data_ready,
  output logic                  o__ret_valid,
  output logic [ADDR_WIDTH-1:0] o__ret_addr,
  input  logic                  i__ret_ready,
  output logic [ADDR_WIDTH:0]   o__count,
  output logic                  o__err
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [ADDR_WIDTH-1:0] ret_q [2];
  logic [ADDR_WIDTH-1:0] ret_d [2];
  logic [1:0]            ret_cnt_q, ret_cnt_d;

  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic wr_fire, rd_fire, ret_pop, ret_full;

  // Write handshake is purely combinational: the handle is whatever the free list presents.
  assign o__wr_ready   = i__free_valid;
  assign o__free_ready = i__wr_valid;
  assign o__wr_addr    = i__free_addr;
  assign wr_fire       = i__wr_valid & i__free_valid;

  assign ret_full      = (ret_cnt_q == 2'd2);
  assign o__rd_ready   = (~rd_valid_q | i__rd_data_ready) & ~ret_full;
  assign rd_fire       = i__rd_valid & o__rd_ready;

  assign o__ret_valid  = (ret_cnt_q != 2'd0);
  assign o__ret_addr   = ret_q[0];
  assign ret_pop       = o__ret_valid & i__ret_ready;

  assign o__rd_data_valid = rd_valid_q;
  assign o__rd_data       = rd_data_q;
  assign o__count         = count_q;

  // NOTE: payload storage has no reset; the reset state is defined by the control registers alone.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[i__free_addr] <= i__wr_data;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    ret_d      = ret_q;
    ret_cnt_d  = ret_cnt_q;
    count_d    = count_q;

    // Old content is returned on a same-edge write since mem_q updates after this sample.
    if (rd_fire) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[i__rd_addr];
    end else if (i__rd_data_ready) begin
      rd_valid_d = 1'b0;
    end

    if (ret_pop) begin
      ret_d[0]  = ret_q[1];
      ret_cnt_d = ret_cnt_d - 2'd1;
    end
    if (rd_fire) begin
      ret_d[ret_cnt_d[0]] = i__rd_addr;
      ret_cnt_d           = ret_cnt_d + 2'd1;
    end

    if (wr_fire && !rd_fire && count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end else if (rd_fire && !wr_fire && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ret_q[0]   <= '0;
      ret_q[1]   <= '0;
      ret_cnt_q  <= 2'd0;
      count_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ret_q      <= ret_d;
      ret_cnt_q  <= ret_cnt_d;
      count_q    <= count_d;
    end
  end

`ifdef PKT_STORE_CHECK_EN
  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic             err_q, err_d;

  always_comb begin
    alloc_d = alloc_q;
    err_d   = err_q;
    if (rd_fire && (!alloc_q[i__rd_addr] || count_q == '0)) begin
      err_d = 1'b1;
    end
    if (wr_fire && alloc_q[i__free_addr]) begin
      err_d = 1'b1;
    end
    // Set after clear so a same-cycle write and read of one handle leaves it allocated.
    if (rd_fire) begin
      alloc_d[i__rd_addr] = 1'b0;
    end
    if (wr_fire) begin
      alloc_d[i__free_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      err_q   <= err_d;
    end
  end

  assign o__err = err_q;
`else
  assign o__err = 1'b0;
`endif

endmodule
